sccb_write_master: RTL and testbench



---
 rtl/sccb_write_master_if.sv | 15 +
 rtl/sccb_write_master.sv | 129 ++++++++++++
 tb/tb_sccb_write_master.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/sccb_write_master_if.sv
// sccb_write_master_if: sequencer-side handshake and SCL line of the SCCB write engine.
//   I2C_DATA : {device address (R/W=0), register, value}, latched on accept
//   enable   : request level from the sequencer
//   I2C_SCL  : SCCB clock line
//   END      : transaction complete, held while enable stays high
//   ACK      : 1 = at least one byte of the last transaction was NACKed
interface sccb_write_master_if;
    logic [23:0] I2C_DATA;
    logic        enable;
    logic        I2C_SCL;
    logic        END;
    logic        ACK;
    modport master (input I2C_DATA, enable, output I2C_SCL, END, ACK);
    modport slave (output I2C_DATA, enable, input I2C_SCL, END, ACK);
endinterface

// File: rtl/sccb_write_master.sv
// sccb_write_master: SCCB/I2C write engine emitting START, three bytes with ack slots, then STOP.
//   clk     : system clock
//   reset   : asynchronous active-high reset; lines return to idle at once
//   bus     : sccb_write_master_if.master (I2C_DATA, enable, I2C_SCL, END, ACK)
//   I2C_SDA : open-drain data line, drives 0 or Z
// Optional macro SCCB_ACK_CHECK_EN: sample the ack slots so ACK reports NACKs.
// Without it the ack slots are released but never sampled and ACK stays 0.
module sccb_write_master #(
    parameter int unsigned CLK_FREQ = 50000000,
    parameter int unsigned SCL_FREQ = 100000,
    parameter int unsigned QDIV     = CLK_FREQ / (4 * SCL_FREQ)
) (
    input  logic                 clk,
    input  logic                 reset,
    sccb_write_master_if.master  bus,
    inout  wire                  I2C_SDA
);
    localparam logic [15:0] QMAX = 16'(QDIV - 1);

    typedef enum logic [2:0] {IDLE, START, BIT, ACKS, STOP, DONE} state_t;

    state_t      state;
    logic [15:0] qcnt;
    logic [1:0]  q;
    logic [2:0]  bit_idx;
    logic [1:0]  byte_idx;
    logic [23:0] shreg;
    logic        nack;
    logic        scl;
    logic        sda_low;
    logic        done;
    logic        ack;
    logic        tick;

    assign tick        = qcnt == QMAX;
    assign I2C_SDA     = sda_low ? 1'b0 : 1'bz;
    assign bus.I2C_SCL = scl;
    assign bus.END     = done;
    assign bus.ACK     = ack;

    // Line levels are registered at the edge that enters each quarter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            qcnt     <= '0;
            q        <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
            shreg    <= '0;
            nack     <= 1'b0;
            scl      <= 1'b1;
            sda_low  <= 1'b0;
            done     <= 1'b0;
            ack      <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.enable) begin
                    state <= START;
                    shreg <= bus.I2C_DATA;
                    nack  <= 1'b0;
                    ack   <= 1'b0;
                    qcnt  <= '0;
                    q     <= '0;
                end
                DONE: if (!bus.enable) begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    qcnt <= tick ? '0 : qcnt + 16'd1;
                    if (tick) begin
                        // q wraps 3 -> 0 on its own at the end of BIT/ACKS cells
                        q <= q + 2'd1;
                        case (state)
                            START: if (q == 2'd0) begin
                                sda_low <= 1'b1;
                            end else begin
                                state    <= BIT;
                                q        <= '0;
                                bit_idx  <= 3'd7;
                                byte_idx <= '0;
                                scl      <= 1'b0;
                                sda_low  <= ~shreg[23];
                            end
                            BIT: if (q == 2'd1) begin
                                scl <= 1'b1;
                            end else if (q == 2'd3) begin
                                shreg   <= {shreg[22:0], 1'b0};
                                bit_idx <= bit_idx - 3'd1;
                                scl     <= 1'b0;
                                // bit 22 becomes the MSB after this shift
                                sda_low <= bit_idx != 3'd0 && !shreg[22];
                                if (bit_idx == 3'd0) state <= ACKS;
                            end
                            ACKS: if (q == 2'd1) begin
                                scl <= 1'b1;
                            end else if (q == 2'd2) begin
`ifdef SCCB_ACK_CHECK_EN
                                if (I2C_SDA) nack <= 1'b1;
`endif
                            end else if (q == 2'd3) begin
                                scl <= 1'b0;
                                if (byte_idx == 2'd2) begin
                                    state   <= STOP;
                                    sda_low <= 1'b1;
                                end else begin
                                    state    <= BIT;
                                    byte_idx <= byte_idx + 2'd1;
                                    bit_idx  <= 3'd7;
                                    sda_low  <= ~shreg[23];
                                end
                            end
                            STOP: if (q == 2'd0) begin
                                scl <= 1'b1;
                            end else if (q == 2'd1) begin
                                sda_low <= 1'b0;
                            end else begin
                                state <= DONE;
                                done  <= 1'b1;
                                ack   <= nack;
                            end
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sccb_write_master.sv
// tb_sccb_write_master: random SCCB write transactions decoded from the bus and scored against expectations.
module tb_sccb_write_master;
    localparam int QDIV = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic slave_low = 1'b0;
    logic [2:0] ack_mask = 3'b111;
    wire sda;
    int chk_cnt = 0;
    int pass_cnt = 0;

    sccb_write_master_if bus();

    pullup (sda);
    assign sda = slave_low ? 1'b0 : 1'bz;

    sccb_write_master #(.QDIV(QDIV)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus),
        .I2C_SDA(sda)
    );

    always #5 clk = ~clk;

    logic [7:0] rx_q[$];
    logic [7:0] cur = '0;
    int bitpos = 0;
    int stops = 0;
    int act = 0;
    logic pscl = 1'b1;
    logic psda = 1'b1;

    // Bus decoder plus a slave that pulls SDA low in the ack slot of each byte it accepts.
    always @(negedge clk) begin
        if (bus.I2C_SCL != pscl || sda != psda) act++;
        if (pscl && bus.I2C_SCL) begin
            if (psda && !sda) begin
                rx_q.delete();
                bitpos = 0;
            end else if (!psda && sda) begin
                stops++;
            end
        end else if (!pscl && bus.I2C_SCL) begin
            if (bitpos < 8) begin
                cur = {cur[6:0], sda};
                if (bitpos == 7) rx_q.push_back(cur);
            end
            bitpos = (bitpos == 8) ? 0 : bitpos + 1;
        end else if (pscl && !bus.I2C_SCL) begin
            slave_low = bitpos == 8 && rx_q.size() > 0 && rx_q.size() <= 3 && ack_mask[rx_q.size() - 1];
        end
        pscl = bus.I2C_SCL;
        psda = sda;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic do_tx(input logic [23:0] data, input logic [2:0] mask, input int drop_at, input int hold);
        int n;
        int st0;
        int hi;
        logic exp_ack;
        logic [7:0] b;
`ifdef SCCB_ACK_CHECK_EN
        exp_ack = ~&mask;
`else
        exp_ack = 1'b0;
`endif
        ack_mask = mask;
        st0 = stops;
        bus.I2C_DATA = data;
        bus.enable = 1'b1;
        n = 0;
        while (!bus.END && n < 2000) begin
            @(negedge clk);
            n++;
            if (n == 1) bus.I2C_DATA = 24'($urandom);
            if (n == drop_at) bus.enable = 1'b0;
        end
        chk("latency", n - 1, 113 * QDIV);
        chk("nbytes", rx_q.size(), 3);
        for (int i = 0; i < 3; i++) begin
            b = data[23 - 8 * i -: 8];
            chk($sformatf("byte%0d", i), rx_q.size() > i ? {24'd0, rx_q[i]} : 32'hFFFF_FFFF, {24'd0, b});
        end
        chk("ack", bus.ACK, exp_ack);
        chk("stop", stops - st0, 1);
        if (drop_at > 0) begin
            @(negedge clk);
            chk("end_width", bus.END, 1'b0);
        end else begin
            hi = 0;
            repeat (hold) begin
                @(negedge clk);
                if (bus.END && bus.I2C_SCL && sda) hi++;
            end
            chk("end_hold", hi, hold);
            bus.enable = 1'b0;
            @(negedge clk);
            chk("end_fall", bus.END, 1'b0);
        end
        chk("ack_hold", bus.ACK, exp_ack);
    endtask

    initial begin
        int n;
        int act0;
        bus.I2C_DATA = '0;
        bus.enable = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_scl", bus.I2C_SCL, 1'b1);
        chk("rst_sda", sda, 1'b1);
        chk("rst_end", bus.END, 1'b0);
        chk("rst_ack", bus.ACK, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        do_tx(24'h42_12_80, 3'b111, 0, 20);
        do_tx(24'h42_12_80, 3'b101, 0, 3);
        do_tx(24'h42_12_80, 3'b111, 0, 1);
        for (int t = 0; t < 6; t++) begin
            if ($urandom_range(0, 1) == 1)
                do_tx(24'($urandom), 3'($urandom_range(0, 7)), $urandom_range(1, 400), 0);
            else
                do_tx(24'($urandom), 3'($urandom_range(0, 7)), 0, $urandom_range(1, 5));
        end
        ack_mask = 3'b111;
        bus.I2C_DATA = 24'h42_12_80;
        bus.enable = 1'b1;
        n = 0;
        while (!(rx_q.size() == 1 && bitpos == 2 && !bus.I2C_SCL) && n < 2000) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("reach_bit5", n < 2000, 1'b1);
        reset = 1'b1;
        bus.enable = 1'b0;
        #1;
        chk("mid_rst_scl", bus.I2C_SCL, 1'b1);
        chk("mid_rst_sda", sda, 1'b1);
        chk("mid_rst_end", bus.END, 1'b0);
        chk("mid_rst_ack", bus.ACK, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        #1;
        act0 = act;
        repeat (100) @(negedge clk);
        #1;
        chk("quiet", act - act0, 0);
        do_tx(24'h42_12_80, 3'b111, 10, 0);
        do_tx(24'($urandom), 3'b011, 0, 2);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
